// File: rtl/vga_pkg.sv
// Shared types and display constants for the VGA test-pattern path.
// Reused by the sync generator and the pattern sequencer.
package vga_pkg;

   typedef enum logic [1:0] {
      SHOW,
      PEND,
      BLANK
   } seq_state_t;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;

   function automatic int unsigned wrap_inc(
      input int unsigned v,
      input int unsigned n
   );
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/vga_edge_detect.sv
// Rising-edge detector for an already synchronized, debounced level.
// The pulse lasts one cycle however long the level stays high.
module vga_edge_detect (
   input  logic clk,
   input  logic reset_n,
   input  logic level_i,
   output logic edge_o
);

   logic prev_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= level_i;
      end
   end

   assign edge_o = reset_n & level_i & ~prev_q;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous test-pattern selector: advances on a button or a timer,
// always switching at frame end with one black frame between patterns.
module vga_pattern_sequencer
   import vga_pkg::*;
#(
   parameter int NUM_PATTERNS = 4,
   parameter int AUTO_FRAMES  = 60,
   parameter int H_ACTIVE     = H_ACTIVE_DEF,
   parameter int V_ACTIVE     = V_ACTIVE_DEF
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [9:0]                      x_pixel,
   input  logic [9:0]                      y_pixel,
   input  logic                            DE,
   input  logic                            btn_next,
   input  logic                            btn_mode,
   output logic [$clog2(NUM_PATTERNS)-1:0] pattern_sel,
   output logic                            blank_out,
   output logic                            mode_auto,
   output logic                            frame_tick,
   output logic [7:0]                      frame_cnt
);

   localparam int PW = $clog2(NUM_PATTERNS);
   localparam int AW = $clog2(AUTO_FRAMES);
   localparam logic [9:0]    X_LAST    = 10'(H_ACTIVE - 1);
   localparam logic [9:0]    Y_LAST    = 10'(V_ACTIVE - 1);
   localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_FRAMES - 1);

   logic          next_edge;
   logic          mode_edge;
   logic          frame_end;
   logic          auto_req;
   logic          req;
   logic [PW-1:0] pat_next;

   logic          tick_q;
   logic [7:0]    frame_cnt_q;
   logic          mode_q;
   logic [AW-1:0] auto_cnt_q;
   logic [AW-1:0] auto_cnt_d;
   seq_state_t    state_q;
   logic [PW-1:0] pat_q;
   logic          blank_q;

   vga_edge_detect u_next_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .level_i (btn_next),
      .edge_o  (next_edge)
   );

   vga_edge_detect u_mode_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .level_i (btn_mode),
      .edge_o  (mode_edge)
   );

   // Only the last active pixel counts; blanking-time coordinates are ignored.
   assign frame_end = DE && (x_pixel == X_LAST) && (y_pixel == Y_LAST);

   assign auto_req = mode_q && tick_q && (auto_cnt_q == AUTO_LAST);
   assign req      = next_edge | auto_req;
   assign pat_next = PW'(wrap_inc(32'(pat_q), NUM_PATTERNS));

   always_comb begin
      auto_cnt_d = auto_cnt_q;
      if (mode_edge) begin
         auto_cnt_d = '0;
      end else if (mode_q && tick_q) begin
         auto_cnt_d = (auto_cnt_q == AUTO_LAST) ? '0 : auto_cnt_q + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tick_q      <= 1'b0;
         frame_cnt_q <= '0;
         mode_q      <= 1'b0;
         auto_cnt_q  <= '0;
      end else begin
         tick_q     <= frame_end;
         mode_q     <= mode_q ^ mode_edge;
         auto_cnt_q <= auto_cnt_d;
         if (tick_q) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
         end
      end
   end

   // Requests outside SHOW are dropped, never queued.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= SHOW;
         pat_q   <= '0;
         blank_q <= 1'b0;
      end else begin
         unique case (state_q)
            SHOW: begin
               if (req && tick_q) begin
                  state_q <= BLANK;
                  pat_q   <= pat_next;
                  blank_q <= 1'b1;
               end else if (req) begin
                  state_q <= PEND;
               end
            end
            PEND: begin
               if (tick_q) begin
                  state_q <= BLANK;
                  pat_q   <= pat_next;
                  blank_q <= 1'b1;
               end
            end
            BLANK: begin
               if (tick_q) begin
                  state_q <= SHOW;
                  blank_q <= 1'b0;
               end
            end
            default: begin
               state_q <= SHOW;
               blank_q <= 1'b0;
            end
         endcase
      end
   end

   assign pattern_sel = pat_q;
   assign blank_out   = blank_q;
   assign mode_auto   = mode_q;
   assign frame_tick  = tick_q;
   assign frame_cnt   = frame_cnt_q;

endmodule
